fft_64: RTL and testbench

Frame-based 64-point radix-2 decimation-in-time complex FFT with a single shared butterfly. It accepts one 11-bit complex sample per clock while loading, computes in place over 192 cycles, and then streams 64 18-bit complex bins in natural order. It sits after the sample front end in the demodulator chain and feeds the bin-processing stage.

---
 rtl/fft_64.sv | 239 +++++++++++++++++++++++
 tb/tb_fft_64.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_64.sv
// fft_64: 64-point radix-2 decimation-in-time complex FFT built around a
// single shared butterfly.
//
// A frame goes through three phases:
//   LOAD    : 64 samples are accepted, sign-extended to 18 bits and written
//             to the working store at bit-reversed addresses.
//   COMPUTE : 6 stages x 32 butterflies, one butterfly per clock, computed
//             in place (combinational read, write-back on the same edge).
//   OUTPUT  : 64 bins are streamed in natural order k = 0..63.
// With valid_a held high one frame takes 320 cycles (64 + 192 + 64).
//
// Ports
//   CLK      in   rising-edge clock
//   RST      in   synchronous reset, active low
//   valid_a  in   input sample qualifier
//   ar, ai   in   11-bit signed input sample (real, imaginary)
//   ready_a  out  high while loading
//   valid_x  out  registered output bin qualifier
//   xk       out  registered output bin index
//   xr, xi   out  registered 18-bit signed output bin (real, imaginary)
//
// Handshake: a sample is taken on a rising edge exactly when valid_a and
// ready_a are both high at that edge; valid_a is ignored while ready_a is
// low. The output side has no back-pressure: a bin is present on every
// cycle that valid_x is high.
//
// Build option
//   FFT64_ROUND_EN  when defined, twiddle products are rounded half-up
//                   (add 512 before the shift by 10); when undefined the
//                   shift floors. The twiddle table is the same either way.
//
// The current phase is held in the internal signal 'state' (state_t).
module fft_64 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_a,
  input  logic [10:0] ar,
  input  logic [10:0] ai,
  output logic        ready_a,
  output logic        valid_x,
  output logic [5:0]  xk,
  output logic [17:0] xr,
  output logic [17:0] xi
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [5:0] n;      // sample counter in LOAD
  logic [2:0] s;      // stage in COMPUTE
  logic [4:0] b;      // butterfly within the stage
  logic [5:0] k;      // bin counter in OUTPUT

  logic load_en;
  logic bfly_en;
  logic out_en;

  // Working store; never reset, every frame overwrites all 64 words.
  logic signed [17:0] mem_r [64];
  logic signed [17:0] mem_i [64];

  // Quantised cos(2*pi*i/64) * 1024 for i = 0..16. The sine of the same
  // angle is the cosine of the complementary index (16 - i).
  function automatic logic signed [11:0] cos_q(input logic [4:0] i);
    case (i)
      5'd0:    cos_q = 12'sd1024;
      5'd1:    cos_q = 12'sd1019;
      5'd2:    cos_q = 12'sd1004;
      5'd3:    cos_q = 12'sd980;
      5'd4:    cos_q = 12'sd946;
      5'd5:    cos_q = 12'sd903;
      5'd6:    cos_q = 12'sd851;
      5'd7:    cos_q = 12'sd792;
      5'd8:    cos_q = 12'sd724;
      5'd9:    cos_q = 12'sd650;
      5'd10:   cos_q = 12'sd569;
      5'd11:   cos_q = 12'sd483;
      5'd12:   cos_q = 12'sd392;
      5'd13:   cos_q = 12'sd297;
      5'd14:   cos_q = 12'sd200;
      5'd15:   cos_q = 12'sd100;
      default: cos_q = 12'sd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // FSM: state register and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= LOAD;
      n     <= 6'd0;
      s     <= 3'd0;
      b     <= 5'd0;
      k     <= 6'd0;
    end else begin
      state <= state_nxt;
      if (load_en) n <= n + 6'd1;
      if (bfly_en) begin
        b <= b + 5'd1;
        if (b == 5'd31) s <= (s == 3'd5) ? 3'd0 : s + 3'd1;
      end
      if (out_en) k <= k + 6'd1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_en && n == 6'd63) state_nxt = COMPUTE;
      COMPUTE: if (s == 3'd5 && b == 5'd31) state_nxt = OUTPUT;
      OUTPUT:  if (k == 6'd63) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    ready_a = (state == LOAD);
    load_en = valid_a && (state == LOAD);
    bfly_en = (state == COMPUTE);
    out_en  = (state == OUTPUT);
  end

  // ---------------------------------------------------------------------
  // Butterfly addressing and twiddle selection
  // ---------------------------------------------------------------------
  logic [5:0] load_addr;
  logic [5:0] b_ext;
  logic [5:0] h;
  logic [5:0] j;
  logic [5:0] top;
  logic [5:0] bot;
  logic [4:0] m;
  logic [4:0] tw_i;
  logic [4:0] tw_ic;
  logic signed [11:0] w_r;
  logic signed [11:0] w_i;

  always_comb begin
    load_addr = {n[0], n[1], n[2], n[3], n[4], n[5]};
    b_ext     = {1'b0, b};
    h         = 6'd1 << s;
    j         = b_ext & (h - 6'd1);
    // (b >> s) selects the group, each group spans 2h words.
    top       = ((b_ext >> s) << (s + 3'd1)) + j;
    bot       = top + h;
    m         = 5'(j << (3'd5 - s));
    tw_i      = {1'b0, m[3:0]};
    tw_ic     = 5'd16 - tw_i;
    // W^m = cos - j*sin; second quadrant folds onto the first.
    if (!m[4]) begin
      w_r = cos_q(tw_i);
      w_i = -cos_q(tw_ic);
    end else begin
      w_r = -cos_q(tw_ic);
      w_i = -cos_q(tw_i);
    end
  end

  // ---------------------------------------------------------------------
  // Butterfly arithmetic
  // ---------------------------------------------------------------------
  logic signed [17:0] a_r;
  logic signed [17:0] a_i;
  logic signed [17:0] d_r;
  logic signed [17:0] d_i;
  logic signed [29:0] p_r;
  logic signed [29:0] p_i;
  logic signed [29:0] q_r;
  logic signed [29:0] q_i;
  logic signed [17:0] t_r;
  logic signed [17:0] t_i;

  always_comb begin
    a_r = mem_r[top];
    a_i = mem_i[top];
    d_r = mem_r[bot];
    d_i = mem_i[bot];
    p_r = 30'(d_r) * 30'(w_r) - 30'(d_i) * 30'(w_i);
    p_i = 30'(d_r) * 30'(w_i) + 30'(d_i) * 30'(w_r);
`ifdef FFT64_ROUND_EN
    q_r = p_r + 30'sd512;
    q_i = p_i + 30'sd512;
`else
    q_r = p_r;
    q_i = p_i;
`endif
    t_r = 18'(q_r >>> 10);
    t_i = 18'(q_i >>> 10);
  end

  // ---------------------------------------------------------------------
  // Working store writes (suppressed on reset edges so an abandoned frame
  // does not disturb anything)
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST && load_en) begin
      mem_r[load_addr] <= {{7{ar[10]}}, ar};
      mem_i[load_addr] <= {{7{ai[10]}}, ai};
    end else if (RST && bfly_en) begin
      mem_r[top] <= a_r + t_r;
      mem_i[top] <= a_i + t_i;
      mem_r[bot] <= a_r - t_r;
      mem_i[bot] <= a_i - t_i;
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_x <= 1'b0;
      xk      <= 6'd0;
      xr      <= 18'd0;
      xi      <= 18'd0;
    end else if (out_en) begin
      valid_x <= 1'b1;
      xk      <= k;
      xr      <= mem_r[k];
      xi      <= mem_i[k];
    end else begin
      valid_x <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_64.sv
// tb_fft_64: self-checking bench for fft_64.
// Expected bins come from a floating-point DFT of each driven frame and are
// queued when the frame is driven; the output monitor pops and compares.
module tb_fft_64;

  localparam real PI = 3.14159265358979323846;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid_a;
  logic [10:0] ar;
  logic [10:0] ai;
  logic        ready_a;
  logic        valid_x;
  logic [5:0]  xk;
  logic [17:0] xr;
  logic [17:0] xi;

  fft_64 dut (
    .CLK     (CLK),
    .RST     (RST),
    .valid_a (valid_a),
    .ar      (ar),
    .ai      (ai),
    .ready_a (ready_a),
    .valid_x (valid_x),
    .xk      (xk),
    .xr      (xr),
    .xi      (xi)
  );

  // ---------------------------------------------------------------------
  // Clock and cycle counter
  // ---------------------------------------------------------------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int d;
    total++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard: {tol[3:0], k[5:0], re[17:0], im[17:0]}
  // ---------------------------------------------------------------------
  logic [45:0] exp_q[$];
  int fr_r[64];
  int fr_i[64];

  function automatic int round_real(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(-v + 0.5);
  endfunction

  task automatic push_expected(input int tol0, input int tol);
    real re, im, ang;
    int  er, ei, t;
    for (int kk = 0; kk < 64; kk++) begin
      re = 0.0;
      im = 0.0;
      for (int nn = 0; nn < 64; nn++) begin
        ang = 2.0 * PI * real'(kk * nn) / 64.0;
        re = re + real'(fr_r[nn]) * $cos(ang) + real'(fr_i[nn]) * $sin(ang);
        im = im + real'(fr_i[nn]) * $cos(ang) - real'(fr_r[nn]) * $sin(ang);
      end
      er = round_real(re);
      ei = round_real(im);
      t  = (kk == 0) ? tol0 : tol;
      exp_q.push_back({4'(t), 6'(kk), 18'(er), 18'(ei)});
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 64; i++) begin
      fr_r[i] = 0;
      fr_i[i] = 0;
    end
  endtask

  task automatic fill_frame(input int vr, input int vi);
    for (int i = 0; i < 64; i++) begin
      fr_r[i] = vr;
      fr_i[i] = vi;
    end
  endtask

  // ---------------------------------------------------------------------
  // Output monitor
  // ---------------------------------------------------------------------
  bit          prev_v    = 1'b0;
  int          run       = 0;
  int          last_run  = 0;
  int          first_cyc = 0;
  logic [45:0] e;

  always @(negedge CLK) begin
    if (valid_x === 1'b1) begin
      if (!prev_v) begin
        first_cyc = cyc;
        run = 0;
      end
      run++;
      if (exp_q.size() == 0) begin
        check("spurious_bin", 1, 0, 0);
      end else begin
        e = exp_q.pop_front();
        check("xk", int'(xk), int'(e[41:36]), 0);
        check("xr", int'($signed(xr)), int'($signed(e[35:18])), int'(e[45:42]));
        check("xi", int'($signed(xi)), int'($signed(e[17:0])), int'(e[45:42]));
      end
      prev_v = 1'b1;
    end else begin
      if (prev_v) last_run = run;
      prev_v = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  int e0_cyc = 0;

  // Drives fr_r/fr_i; returns the cycles spent waiting for ready_a before
  // sample 0. Leaves valid_a as it was after the last sample.
  task automatic drive_frame(input bit gap, input bit push, input int tol0,
                             input int tol, output int wait0);
    int w;
    wait0 = 0;
    if (push) push_expected(tol0, tol);
    for (int nn = 0; nn < 64; nn++) begin
      if (gap) begin
        valid_a = 1'b0;
        @(posedge CLK);
        #1;
      end
      valid_a = 1'b1;
      ar = 11'(fr_r[nn]);
      ai = 11'(fr_i[nn]);
      w = 0;
      while (ready_a !== 1'b1 && w < 400) begin
        @(posedge CLK);
        #1;
        w++;
      end
      if (w >= 400) check("ready_timeout", 0, 1, 0);
      if (nn == 0) wait0 = w;
      @(posedge CLK);
      #1;
    end
    e0_cyc = cyc;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 1000) begin
      @(posedge CLK);
      w++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0, 0);
      exp_q.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input bit gap, input int tol0, input int tol);
    int w0;
    drive_frame(gap, 1'b1, tol0, tol, w0);
    valid_a = 1'b0;
    drain();
    check("latency", first_cyc - e0_cyc, 193, 0);
    check("valid_len", last_run, 64, 0);
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  int w0;
  int lo_cnt;
  int vcnt;
  int rv_r;
  int rv_i;

  initial begin
    RST     = 1'b0;
    valid_a = 1'b0;
    ar      = 11'd0;
    ai      = 11'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid_x", int'(valid_x), 0, 0);
    check("rst_xk", int'(xk), 0, 0);
    check("rst_xr", int'(xr), 0, 0);
    check("rst_xi", int'(xi), 0, 0);
    check("rst_ready_a", int'(ready_a), 1, 0);
    RST = 1'b1;

    // Impulse at sample 0: every bin exactly 100+j0.
    clear_frame();
    fr_r[0] = 100;
    run_frame(1'b0, 0, 0);

    // DC 10+j0: bin 0 exact, others near zero.
    fill_frame(10, 0);
    run_frame(1'b0, 0, 2);

    // Random complex DC level.
    rv_r = int'($urandom_range(0, 2047)) - 1024;
    rv_i = int'($urandom_range(0, 2047)) - 1024;
    fill_frame(rv_r, rv_i);
    run_frame(1'b0, 0, 2);

    // Shifted impulse at sample 10.
    clear_frame();
    fr_r[10] = 100;
    run_frame(1'b0, 2, 2);

    // Full-scale negative corner: bin 0 = -65536-j65536 without wrap.
    fill_frame(-1024, -1024);
    run_frame(1'b0, 0, 2);

    // Gapped input, valid_a toggling every cycle.
    clear_frame();
    fr_r[10] = 100;
    run_frame(1'b1, 2, 2);

    // Reset during COMPUTE abandons the frame.
    fill_frame(5, 5);
    drive_frame(1'b0, 1'b0, 0, 0, w0);
    valid_a = 1'b0;
    repeat (int'($urandom_range(10, 150))) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    check("midrst_ready_a", int'(ready_a), 1, 0);
    check("midrst_valid_x", int'(valid_x), 0, 0);
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (valid_x === 1'b1) vcnt++;
    end
    check("midrst_no_output", vcnt, 0, 0);
    #1;
    clear_frame();
    fr_r[0] = 100;
    run_frame(1'b0, 0, 0);

    // Back-to-back frames with valid_a held high.
    clear_frame();
    fr_r[10] = 100;
    drive_frame(1'b0, 1'b1, 2, 2, w0);
    fill_frame(-7, 3);
    drive_frame(1'b0, 1'b1, 0, 2, lo_cnt);
    check("b2b_ready_low", lo_cnt, 256, 0);
    valid_a = 1'b0;
    drain();
    check("b2b_latency", first_cyc - e0_cyc, 193, 0);
    check("b2b_valid_len", last_run, 64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
